// File: rtl/mult_row_sequencer.sv
// Round-robin drain of the per-lane product FIFOs into a signed row accumulator.
// One dot-product result per programmed row, returned over a valid/ready handshake.
module mult_row_sequencer #(
    parameter int LANES = 4,
    parameter int PW    = 16,
    parameter int LW    = 16,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*PW-1:0] mult,
    input  logic [LANES-1:0]    mult_fifo_empty,
    output logic [LANES-1:0]    mult_fifo_read,
    input  logic [LW-1:0]       row_len,
    input  logic                row_len_valid,
    output logic                row_len_ready,
    output logic [AW-1:0]       sum,
    output logic                sum_valid,
    input  logic                sum_ready,
    output logic                busy
);

    localparam int PTRW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [LW-1:0]   remaining_q, remaining_d;

    logic [PW-1:0]   lane_prod;
    logic [AW-1:0]   lane_prod_ext;
    logic            lane_pop;

    // Only the lane under the pointer may be popped, so the global interleave never skips ahead.
    assign lane_prod     = mult[PW*ptr_q +: PW];
    assign lane_prod_ext = {{(AW-PW){lane_prod[PW-1]}}, lane_prod};
    assign lane_pop      = (state_q == ACCUM) && !mult_fifo_empty[ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            acc_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (row_len_valid) begin
                    state_d = (row_len == '0) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                if (lane_pop && (remaining_q == LW'(1))) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pointer is deliberately left alone at row boundaries.
    always_comb begin
        ptr_d       = ptr_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        if ((state_q == IDLE) && row_len_valid) begin
            acc_d       = '0;
            remaining_d = row_len;
        end else if (lane_pop) begin
            acc_d       = acc_q + lane_prod_ext;
            remaining_d = remaining_q - LW'(1);
            ptr_d       = (ptr_q == PTRW'(LANES-1)) ? '0 : ptr_q + PTRW'(1);
        end
    end

    always_comb begin
        mult_fifo_read = '0;
        if (lane_pop) begin
            mult_fifo_read = {{(LANES-1){1'b0}}, 1'b1} << ptr_q;
        end
        row_len_ready = (state_q == IDLE);
        sum_valid     = (state_q == OUTPUT);
        busy          = (state_q != IDLE);
    end

    assign sum = acc_q;

endmodule

// File: tb/tb_mult_row_sequencer.sv
// Directed bench for mult_row_sequencer: inputs change 1 time unit after the rising edge,
// outputs are sampled 2 units later, well away from either clock edge.
module tb_mult_row_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] mult;
    logic [3:0]  mult_fifo_empty;
    logic [3:0]  mult_fifo_read;
    logic [15:0] row_len;
    logic        row_len_valid;
    logic        row_len_ready;
    logic [31:0] sum;
    logic        sum_valid;
    logic        sum_ready;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    mult_row_sequencer #(
        .LANES(4),
        .PW(16),
        .LW(16),
        .AW(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mult           (mult),
        .mult_fifo_empty(mult_fifo_empty),
        .mult_fifo_read (mult_fifo_read),
        .row_len        (row_len),
        .row_len_valid  (row_len_valid),
        .row_len_ready  (row_len_ready),
        .sum            (sum),
        .sum_valid      (sum_valid),
        .sum_ready      (sum_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic set_lanes(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3);
        mult = {p3, p2, p1, p0};
    endtask

    // Offers a row for exactly one edge (cycle 0) and returns at the cycle 1 sample point.
    task automatic start_row(input logic [15:0] n, input logic sr);
        go();
        row_len       = n;
        row_len_valid = 1'b1;
        sum_ready     = sr;
        look();
        check_output("accept_ready", {31'd0, row_len_ready}, 32'd1);
        check_output("accept_noread", {28'd0, mult_fifo_read}, 32'd0);
        go();
        row_len_valid = 1'b0;
        look();
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_sum_valid"}, {31'd0, sum_valid}, 32'd0);
        check_output({tag, "_ready"}, {31'd0, row_len_ready}, 32'd1);
        check_output({tag, "_read"}, {28'd0, mult_fifo_read}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_rd;

        rst             = 1'b0;
        mult            = '0;
        mult_fifo_empty = 4'hF;
        row_len         = '0;
        row_len_valid   = 1'b0;
        sum_ready       = 1'b1;

        go();
        look();
        check_idle("por");
        check_output("por_sum", sum, 32'd0);
        go();
        rst = 1'b1;
        look();

        // Basic row: 0 + 36 - 112 + 75 = -1
        set_lanes(16'h0000, 16'h0024, 16'hFF90, 16'h004B);
        mult_fifo_empty = 4'h0;
        start_row(16'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                go();
                look();
            end
            exp_rd = 4'b0001 << i;
            check_output($sformatf("basic_read%0d", i), {28'd0, mult_fifo_read}, {28'd0, exp_rd});
            check_output($sformatf("basic_busy%0d", i), {31'd0, busy}, 32'd1);
        end
        go();
        look();
        check_output("basic_sum_valid", {31'd0, sum_valid}, 32'd1);
        check_output("basic_sum", sum, 32'hFFFF_FFFF);
        check_output("basic_out_noread", {28'd0, mult_fifo_read}, 32'd0);
        go();
        look();
        check_idle("basic_done");

        // Pointer wrap: row of 3 leaves the pointer on lane 3
        start_row(16'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                go();
                look();
            end
            exp_rd = 4'b0001 << i;
            check_output($sformatf("wrapA_read%0d", i), {28'd0, mult_fifo_read}, {28'd0, exp_rd});
        end
        go();
        look();
        check_output("wrapA_sum", sum, 32'hFFFF_FFB4);
        check_output("wrapA_sum_valid", {31'd0, sum_valid}, 32'd1);
        go();
        look();
        start_row(16'd2, 1'b1);
        check_output("wrapB_read0", {28'd0, mult_fifo_read}, 32'h8);
        go();
        look();
        check_output("wrapB_read1", {28'd0, mult_fifo_read}, 32'h1);
        go();
        look();
        check_output("wrapB_sum", sum, 32'h0000_004B);
        check_output("wrapB_sum_valid", {31'd0, sum_valid}, 32'd1);
        go();
        look();
        check_idle("wrapB_done");

        // Reset mid-row: pointer sits on lane 1, partial sum of 36 must vanish
        start_row(16'd4, 1'b1);
        check_output("rst_pre_read0", {28'd0, mult_fifo_read}, 32'h2);
        go();
        look();
        check_output("rst_pre_read1", {28'd0, mult_fifo_read}, 32'h4);
        check_output("rst_pre_sum", sum, 32'h0000_0024);
        #1;
        rst = 1'b0;
        #1;
        check_output("rst_async_read", {28'd0, mult_fifo_read}, 32'd0);
        check_output("rst_async_sum", sum, 32'd0);
        check_output("rst_async_busy", {31'd0, busy}, 32'd0);
        check_output("rst_async_ready", {31'd0, row_len_ready}, 32'd1);
        go();
        rst = 1'b1;
        look();
        check_idle("rst_released");
        check_output("rst_released_sum", sum, 32'd0);

        // Stall: lane 1 empty in cycles 2..4, lane 2 must not be read early
        set_lanes(16'd100, 16'd200, 16'd300, 16'd400);
        start_row(16'd4, 1'b1);
        check_output("stall_c1_read", {28'd0, mult_fifo_read}, 32'h1);
        for (int c = 2; c <= 4; c++) begin
            go();
            mult_fifo_empty = 4'b0010;
            look();
            check_output($sformatf("stall_c%0d_read", c), {28'd0, mult_fifo_read}, 32'd0);
            check_output($sformatf("stall_c%0d_busy", c), {31'd0, busy}, 32'd1);
        end
        for (int c = 5; c <= 7; c++) begin
            go();
            mult_fifo_empty = 4'b0000;
            look();
            exp_rd = 4'b0001 << (c - 4);
            check_output($sformatf("stall_c%0d_read", c), {28'd0, mult_fifo_read}, {28'd0, exp_rd});
            check_output($sformatf("stall_c%0d_nvalid", c), {31'd0, sum_valid}, 32'd0);
        end
        go();
        look();
        check_output("stall_c8_valid", {31'd0, sum_valid}, 32'd1);
        check_output("stall_c8_sum", sum, 32'h0000_03E8);
        go();
        look();
        check_idle("stall_done");

        // Zero-length row with five cycles of back-pressure
        start_row(16'd0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                go();
                look();
            end
            check_output($sformatf("zero_c%0d_valid", c), {31'd0, sum_valid}, 32'd1);
            check_output($sformatf("zero_c%0d_sum", c), sum, 32'd0);
            check_output($sformatf("zero_c%0d_ready", c), {31'd0, row_len_ready}, 32'd0);
            check_output($sformatf("zero_c%0d_busy", c), {31'd0, busy}, 32'd1);
            check_output($sformatf("zero_c%0d_read", c), {28'd0, mult_fifo_read}, 32'd0);
        end
        go();
        sum_ready = 1'b1;
        look();
        check_output("zero_c6_valid", {31'd0, sum_valid}, 32'd1);
        go();
        look();
        check_idle("zero_done");

        // Extreme: eight products of -32768
        set_lanes(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        start_row(16'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                go();
                look();
            end
            exp_rd = 4'b0001 << (i % 4);
            check_output($sformatf("ext_read%0d", i), {28'd0, mult_fifo_read}, {28'd0, exp_rd});
        end
        go();
        look();
        check_output("ext_valid", {31'd0, sum_valid}, 32'd1);
        check_output("ext_sum", sum, 32'hFFFC_0000);
        go();
        look();
        check_idle("ext_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_row_sequencer.md
# mult_row_sequencer

Sequences the per-lane product FIFOs of the multi-lane `channel` multiplier into one row accumulator. It drains the lanes in strict round-robin order, one product per cycle, and sums signed products for a programmed row length. It emits one dot-product result per row over a valid/ready handshake. It sits directly downstream of `channel` and owns its `mult_fifo_read` strobes.

## Interface
- `LANES`, 4, number of product lanes (matches `channel`)
- `PW`, 16, signed product width per lane
- `LW`, 16, row-length width
- `AW`, 32, accumulator/result width; AW ≥ PW+LW guarantees no overflow
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mult`  in  LANES*PW  lane i product at `mult[PW*i +: PW]`; first-word-fall-through, valid while lane not empty
- `mult_fifo_empty`  in  LANES  per-lane empty flag
- `mult_fifo_read`  out  LANES  one-hot pop strobe; pops at the clock edge
- `row_len`  in  LW  number of products in the next row (unsigned)
- `row_len_valid`  in  1  row_len offered
- `row_len_ready`  out  1  sequencer accepts a row
- `sum`  out  AW  signed row sum
- `sum_valid`  out  1  sum presented
- `sum_ready`  in  1  consumer takes sum
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - `row_len_ready`=1.
  - On `row_len_valid`: acc←0, remaining←row_len.
  - Next state is ACCUM if row_len≠0, else OUTPUT.
- ACCUM:
  - Lane pointer `ptr` selects the only lane eligible this cycle.
  - If `mult_fifo_empty[ptr]`=0: `mult_fifo_read`=1<<ptr, acc←acc+sext(lane ptr product), remaining←remaining−1, ptr←(ptr+1) mod LANES.
  - If the lane is empty: stall. No read, nothing changes; other non-empty lanes are never read out of order.
  - When the pop makes remaining reach 0, go to OUTPUT.
- OUTPUT:
  - `sum_valid`=1, `sum`=acc, held stable.
  - On `sum_ready`, go to IDLE.
- `ptr` persists across rows. It is never reset by row boundaries, so the product stream is interleaved lane0,1,2,3,0,… globally.
- Arithmetic: products are sign-extended PW→AW and summed modulo 2^AW (wrap; no saturation or flag).
- `mult_fifo_read`=0 in every state except ACCUM. `row_len_ready`=0 except in IDLE.

## Timing
- `mult_fifo_read`, `row_len_ready`, `sum_valid` and `busy` are combinational from registered state and `mult_fifo_empty`. `sum` comes directly from the acc register.
- Row handshake completes at the edge where `row_len_valid`&`row_len_ready`. That is cycle 0.
- Row of N, no stalls: reads in cycles 1..N, `sum_valid` from cycle N+1.
- Row of 0: `sum_valid` in cycle 1, sum=0, no reads.
- Each stall cycle adds one cycle. Each `sum_ready`-low cycle adds one cycle.
- Minimum spacing between row accepts is N+2 cycles.
- Reset (`rst`=0, asynchronous, any state, including mid-ACCUM):
  - State→IDLE, ptr→0, acc→0, remaining→0.
  - Outputs: `mult_fifo_read`=0, `sum`=0, `sum_valid`=0, `busy`=0, `row_len_ready`=1.
  - A partial row is discarded; products already popped are lost.
- Changes on `row_len` while not ready are ignored.

## Test plan
- Reset: assert `rst`=0 mid-ACCUM with lanes non-empty.
  - `mult_fifo_read` drops to 0 immediately, before the next edge.
  - After release: `sum_valid`=0, `sum`=0, `busy`=0, `row_len_ready`=1, next read on lane 0.
- Basic row: lanes 0..3 = 0, 36, −112, 75, all non-empty, row_len=4, `sum_ready`=1.
  - Reads 0001, 0010, 0100, 1000 in cycles 1–4.
  - `sum_valid` in cycle 5 with sum=0xFFFFFFFF (−1), then IDLE.
- Pointer wrap across rows: row_len=3 (lanes 0–2), then row_len=2.
  - Second row reads lane 3 then lane 0.
  - Second sum = lane3+lane0 products.
- Stall ordering: row_len=4, lane 1 empty for cycles 2–4, lane 2 non-empty.
  - No reads in those cycles; lane 2 is not read early.
  - Reads resume 0010 at cycle 5; `sum_valid` at cycle 8.
- Zero row and back-pressure: row_len=0.
  - `sum_valid` at cycle 1 with sum=0, no reads.
  - Hold `sum_ready`=0 for 5 cycles: sum stable, `row_len_ready`=0, `busy`=1, no reads.
- Extreme values: row_len=8, every product −32768.
  - sum=−262144 (0xFFFC0000), no wrap.
